sipo_deser_param: RTL and testbench

//   Parametrised serial-in/parallel-out deserialiser. Shifts a qualified serial
//   bit stream into a WIDTH-bit register and presents each completed frame on a

---
 rtl/sipo_deser_param.sv | 118 +++++++++++
 tb/tb_sipo_deser_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser_param.sv
// sipo_deser_param: parametrised serial-in/parallel-out deserialiser.
//   Shifts qualified serial bits into a WIDTH-bit register. Each completed frame
//   is presented on a registered parallel port with a valid/ready handshake. A
//   sticky overrun flag is raised when a frame completes while the previous one
//   is still pending and not being accepted.
// Parameters:
//   WIDTH     : frame width in bits (>= 2)
//   MSB_FIRST : 1 -> first received bit lands in pa_out[WIDTH-1], 0 -> pa_out[0]
// Ports:
//   clk       : clock, all updates on posedge
//   rst       : asynchronous active-low reset
//   se_in     : serial data bit
//   se_valid  : se_in qualifier
//   clr       : synchronous clear of frame state and flags
//   pa_ready  : consumer accepts pa_out this cycle
//   pa_out    : last completed frame (registered)
//   pa_valid  : pa_out holds an unaccepted frame (registered)
//   ovf       : sticky overrun flag (registered)
//   busy      : partial frame in progress, decoded from the bit counter
module sipo_deser_param #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se_in,
  input  logic             se_valid,
  input  logic             clr,
  input  logic             pa_ready,
  output logic [WIDTH-1:0] pa_out,
  output logic             pa_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pa_out_q, pa_out_d;
  logic             pa_valid_q, pa_valid_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sr_shift;
  logic             frame_done;
  logic             xfer;

  // Shift-register value after taking se_in, in the configured bit order
  always_comb begin
    sr_shift = sr_q;
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-2:0], se_in};
    end else begin
      sr_shift = {se_in, sr_q[WIDTH-1:1]};
    end
  end

  assign frame_done = se_valid && (cnt_q == CNT_LAST);
  assign xfer       = pa_valid_q && pa_ready;

  // Next-state: clear dominates; a completion reloads the output even when a
  // transfer happens on the same edge, so back-to-back frames need no bubble.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pa_out_d   = pa_out_q;
    pa_valid_d = pa_valid_q;
    ovf_d      = ovf_q;

    if (clr) begin
      sr_d       = '0;
      cnt_d      = '0;
      pa_out_d   = '0;
      pa_valid_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      if (se_valid) begin
        sr_d  = sr_shift;
        cnt_d = frame_done ? '0 : cnt_q + CNT_W'(1);
      end

      if (frame_done) begin
        pa_out_d   = sr_shift;
        pa_valid_d = 1'b1;
        // Pending frame overwritten without being taken
        if (pa_valid_q && !pa_ready) begin
          ovf_d = 1'b1;
        end
      end else if (xfer) begin
        pa_valid_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      pa_out_q   <= '0;
      pa_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pa_out_q   <= pa_out_d;
      pa_valid_q <= pa_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pa_out   = pa_out_q;
  assign pa_valid = pa_valid_q;
  assign ovf      = ovf_q;
  assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deser_param.sv
// Testbench for sipo_deser_param: MSB-first and LSB-first instances share stimulus.
// Accepted frames from the MSB-first instance are matched against a scoreboard.
module tb_sipo_deser_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       se_in, se_valid, clr, pa_ready;
  logic [7:0] pa_out_m, pa_out_l;
  logic       pa_valid_m, pa_valid_l, ovf_m, ovf_l, busy_m, busy_l;

  int nchk = 0;
  int nerr = 0;

  // Scoreboard and reference state for the MSB-first instance
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] m_sr;
  int         m_cnt;
  logic       m_valid, m_ovf;

  always #5 clk = ~clk;

  sipo_deser_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .se_in(se_in), .se_valid(se_valid), .clr(clr),
    .pa_ready(pa_ready), .pa_out(pa_out_m), .pa_valid(pa_valid_m),
    .ovf(ovf_m), .busy(busy_m)
  );

  sipo_deser_param #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .se_in(se_in), .se_valid(se_valid), .clr(clr),
    .pa_ready(pa_ready), .pa_out(pa_out_l), .pa_valid(pa_valid_l),
    .ovf(ovf_l), .busy(busy_l)
  );

  task automatic model_reset();
    m_sr = 8'h00; m_cnt = 0; m_valid = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Drive one clock edge; record any transfer seen by the DUT and update the model
  task automatic drive(input logic v, input logic b, input logic rdy, input logic c);
    logic compl;
    se_valid = v; se_in = b; pa_ready = rdy; clr = c;
    if (pa_valid_m && rdy && !c) obs_q.push_back(pa_out_m);
    if (c) begin
      m_sr = 8'h00; m_cnt = 0; m_valid = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      compl = v && (m_cnt == 7);
      if (v) m_sr = {m_sr[6:0], b};
      if (compl) begin
        if (m_valid && !rdy) begin
          m_ovf = 1'b1;
          void'(exp_q.pop_back());
        end
        exp_q.push_back(m_sr);
        m_valid = 1'b1;
        m_cnt   = 0;
      end else begin
        if (v) m_cnt++;
        if (m_valid && rdy) m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] f, input logic rdy_body, input logic rdy_last);
    for (int i = 7; i >= 0; i--) drive(1'b1, f[i], (i == 0) ? rdy_last : rdy_body, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; se_in = 1'b1; se_valid = 1'b1; clr = 1'b0; pa_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    nchk++; if (pa_out_m !== 8'h00) begin nerr++; $display("FAIL reset_pa_out got %h want 00", pa_out_m); end
    nchk++; if (pa_valid_m !== 1'b0) begin nerr++; $display("FAIL reset_pa_valid got %b want 0", pa_valid_m); end
    nchk++; if (ovf_m !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b want 0", ovf_m); end
    nchk++; if (busy_m !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy_m); end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bit sequence 1,0,1,1,0,0,1,0 with pa_ready low; check busy per edge and both orders
  task automatic test_bit_order();
    logic [7:0] f = 8'hB2;
    logic [7:0] got, want;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, f[i], 1'b0, 1'b0);
      nchk++;
      if (busy_m !== (i != 0)) begin
        nerr++; $display("FAIL order_busy edge %0d got %b want %b", 8 - i, busy_m, (i != 0));
      end
      if (i != 0) begin
        nchk++;
        if (pa_valid_m !== 1'b0) begin nerr++; $display("FAIL order_early_valid edge %0d got %b want 0", 8 - i, pa_valid_m); end
      end
    end
    nchk++; if (pa_out_m !== 8'hB2) begin nerr++; $display("FAIL order_msb_pa_out got %h want b2", pa_out_m); end
    nchk++; if (pa_valid_m !== 1'b1) begin nerr++; $display("FAIL order_pa_valid got %b want 1", pa_valid_m); end
    nchk++; if (pa_out_l !== 8'h4D) begin nerr++; $display("FAIL order_lsb_pa_out got %h want 4d", pa_out_l); end
    nchk++; if (pa_valid_l !== 1'b1) begin nerr++; $display("FAIL order_lsb_valid got %b want 1", pa_valid_l); end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    nchk++; if (pa_valid_m !== 1'b0) begin nerr++; $display("FAIL order_accept_valid got %b want 0", pa_valid_m); end
    nchk++; if (obs_q.size() !== 1) begin nerr++; $display("FAIL order_xfer_count got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      nchk++; if (got !== want) begin nerr++; $display("FAIL order_scoreboard got %h want %h", got, want); end
    end
  endtask

  // Three idle cycles between bits 4 and 5; previous frame must not move
  task automatic test_gap();
    logic [7:0] f = 8'hB2;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b0);
    for (int i = 7; i >= 4; i--) drive(1'b1, f[i], 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      nchk++; if (busy_m !== 1'b1) begin nerr++; $display("FAIL gap_busy cycle %0d got %b want 1", g, busy_m); end
    end
    nchk++; if (pa_out_m !== 8'h55) begin nerr++; $display("FAIL gap_pa_out_hold got %h want 55", pa_out_m); end
    for (int i = 3; i >= 1; i--) drive(1'b1, f[i], 1'b0, 1'b0);
    nchk++; if (pa_out_m !== 8'h55) begin nerr++; $display("FAIL gap_before_last got %h want 55", pa_out_m); end
    drive(1'b1, f[0], 1'b0, 1'b0);
    nchk++; if (pa_out_m !== 8'hB2) begin nerr++; $display("FAIL gap_pa_out got %h want b2", pa_out_m); end
    nchk++; if (ovf_m !== m_ovf) begin nerr++; $display("FAIL gap_ovf got %b want %b", ovf_m, m_ovf); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    obs_q.delete();
  endtask

  // ready held high across two frames, then a transfer coinciding with a completion
  task automatic test_back_to_back();
    logic [7:0] got, want;
    send(8'hB2, 1'b1, 1'b1);
    nchk++; if (pa_out_m !== 8'hB2) begin nerr++; $display("FAIL b2b_first got %h want b2", pa_out_m); end
    send(8'h0F, 1'b1, 1'b1);
    nchk++; if (pa_out_m !== 8'h0F) begin nerr++; $display("FAIL b2b_second got %h want 0f", pa_out_m); end
    nchk++; if (pa_valid_m !== 1'b1) begin nerr++; $display("FAIL b2b_valid got %b want 1", pa_valid_m); end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h5A, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b1);
    nchk++; if (pa_valid_m !== 1'b1) begin nerr++; $display("FAIL b2b_same_edge_valid got %b want 1", pa_valid_m); end
    nchk++; if (pa_out_m !== 8'hC3) begin nerr++; $display("FAIL b2b_same_edge_out got %h want c3", pa_out_m); end
    nchk++; if (ovf_m !== 1'b0) begin nerr++; $display("FAIL b2b_ovf got %b want 0", ovf_m); end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    nchk++; if (obs_q.size() !== 4) begin nerr++; $display("FAIL b2b_xfer_count got %0d want 4", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      nchk++; if (got !== want) begin nerr++; $display("FAIL b2b_scoreboard got %h want %h", got, want); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] got, want;
    send(8'hB2, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    nchk++; if (pa_out_m !== 8'h0F) begin nerr++; $display("FAIL ovr_pa_out got %h want 0f", pa_out_m); end
    nchk++; if (ovf_m !== 1'b1) begin nerr++; $display("FAIL ovr_ovf got %b want 1", ovf_m); end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    nchk++; if (ovf_m !== 1'b1) begin nerr++; $display("FAIL ovr_sticky got %b want 1", ovf_m); end
    nchk++; if (obs_q.size() !== 1) begin nerr++; $display("FAIL ovr_xfer_count got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      nchk++; if (got !== want) begin nerr++; $display("FAIL ovr_scoreboard got %h want %h", got, want); end
    end
    // Leave a pending frame and 3 partial bits, then clear with se_valid high
    send(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    nchk++; if (ovf_m !== 1'b0) begin nerr++; $display("FAIL clr_ovf got %b want 0", ovf_m); end
    nchk++; if (pa_valid_m !== 1'b0) begin nerr++; $display("FAIL clr_pa_valid got %b want 0", pa_valid_m); end
    nchk++; if (pa_out_m !== 8'h00) begin nerr++; $display("FAIL clr_pa_out got %h want 00", pa_out_m); end
    nchk++; if (busy_m !== 1'b0) begin nerr++; $display("FAIL clr_busy got %b want 0", busy_m); end
    send(8'h96, 1'b0, 1'b0);
    nchk++; if (pa_out_m !== 8'h96) begin nerr++; $display("FAIL clr_next_frame got %h want 96", pa_out_m); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    obs_q.delete();
  endtask

  // Asynchronous reset between edges after 5 bits; following frame must be clean
  task automatic test_async_reset();
    logic [7:0] got, want;
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, i[0], 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    nchk++; if (pa_out_m !== 8'h00) begin nerr++; $display("FAIL arst_pa_out got %h want 00", pa_out_m); end
    nchk++; if (pa_valid_m !== 1'b0) begin nerr++; $display("FAIL arst_pa_valid got %b want 0", pa_valid_m); end
    nchk++; if (ovf_m !== 1'b0) begin nerr++; $display("FAIL arst_ovf got %b want 0", ovf_m); end
    nchk++; if (busy_m !== 1'b0) begin nerr++; $display("FAIL arst_busy got %b want 0", busy_m); end
    model_reset();
    #1;
    rst = 1'b1;
    send(8'h3C, 1'b0, 1'b0);
    nchk++; if (pa_out_m !== 8'h3C) begin nerr++; $display("FAIL arst_msb_frame got %h want 3c", pa_out_m); end
    nchk++; if (pa_out_l !== 8'h3C) begin nerr++; $display("FAIL arst_lsb_frame got %h want 3c", pa_out_l); end
    nchk++; if (pa_valid_m !== 1'b1) begin nerr++; $display("FAIL arst_valid got %b want 1", pa_valid_m); end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    nchk++; if (obs_q.size() !== 1) begin nerr++; $display("FAIL arst_xfer_count got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      nchk++; if (got !== want) begin nerr++; $display("FAIL arst_scoreboard got %h want %h", got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_gap();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
